// File: rtl/dsi_sched_pkg.sv
// dsi_sched_pkg: shared state, source-select and mode encodings for the DSI TX packet scheduler.
package dsi_sched_pkg;

    typedef enum logic [2:0] {IDLE, ARB, START, TX, GAP} state_t;

    typedef enum logic {SRC_VID, SRC_CMD} src_t;

    localparam logic MODE_HS = 1'b0;
    localparam logic MODE_LP = 1'b1;

endpackage

// File: rtl/dsi_sched_wdog.sv
// dsi_sched_wdog: loadable down-counter shared by the inter-packet gap and the TX stall watchdog.
module dsi_sched_wdog #(
    parameter int W = 11
) (
    input  logic         clk_sys,
    input  logic         rst_n,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n)
            cnt <= '0;
        else if (load)
            cnt <= load_val;
        else if (cnt != '0)
            cnt <= cnt - 1'b1;

    assign done = cnt == '0;

endmodule

// File: rtl/dsi_tx_packet_scheduler.sv
// dsi_tx_packet_scheduler: arbitrates video and command packets onto the DSI lanes packet write interface,
// with inter-packet gap, command anti-starvation and stall abort.
module dsi_tx_packet_scheduler
    import dsi_sched_pkg::*;
#(
    parameter int GAP_CYCLES     = 8,
    parameter int STARVE_LIMIT   = 4,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        enable,
    input  logic        lanes_ready,
    input  logic        vid_valid,
    input  logic [31:0] vid_data,
    input  logic [3:0]  vid_strb,
    input  logic        vid_last,
    output logic        vid_ack,
    input  logic        cmd_valid,
    input  logic [31:0] cmd_data,
    input  logic [3:0]  cmd_strb,
    input  logic        cmd_lp,
    input  logic        cmd_last,
    output logic        cmd_ack,
    output logic [31:0] lanes_write_data,
    output logic [4:0]  lanes_write_strb,
    output logic        lanes_write_rqst,
    output logic        lanes_last_word,
    input  logic        lanes_data_rqst,
    output logic        busy,
    output logic        grant_cmd,
    output logic        err_underrun,
    output logic        err_timeout
);

    localparam int CW = $clog2((TIMEOUT_CYCLES > GAP_CYCLES ? TIMEOUT_CYCLES : GAP_CYCLES) + 1);

    state_t        state, next;
    src_t          src;
    logic          mode;
    logic [3:0]    starve;
    logic          done, load;
    logic [CW-1:0] load_val;
    logic          s_valid, s_last, grant_c, underrun, timeout, live, ack;

    assign s_valid  = src == SRC_CMD ? cmd_valid : vid_valid;
    assign s_last   = src == SRC_CMD ? cmd_last : vid_last;
    assign grant_c  = cmd_valid && (starve == 4'(STARVE_LIMIT) || !vid_valid);
    assign underrun = state == TX && lanes_ready && lanes_data_rqst && !s_valid;
    assign timeout  = state == TX && lanes_ready && !lanes_data_rqst && done;
    assign live     = state == START || state == TX;
    assign ack      = state == TX && lanes_ready && lanes_data_rqst && s_valid;

    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n)
            state <= IDLE;
        else
            state <= next;

    always_comb begin
        next = state;
        case (state)
            IDLE:    next = enable && lanes_ready && done ? ARB : IDLE;
            ARB:     next = cmd_valid || vid_valid ? START : IDLE;
            START:   next = lanes_ready ? TX : GAP;
            TX:      next = !lanes_ready || underrun || timeout || (lanes_data_rqst && s_last) ? GAP : TX;
            GAP:     next = done ? IDLE : GAP;
            default: next = IDLE;
        endcase
    end

    always_comb begin
        busy             = live;
        lanes_write_rqst = state == START;
        lanes_write_data = live ? (src == SRC_CMD ? cmd_data : vid_data) : '0;
        lanes_write_strb = live ? {mode, src == SRC_CMD ? cmd_strb : vid_strb} : '0;
        lanes_last_word  = live && s_last;
        vid_ack          = ack && src == SRC_VID;
        cmd_ack          = ack && src == SRC_CMD;
        grant_cmd        = src == SRC_CMD;
    end

    // One counter: loaded with the gap on any entry to GAP, with the watchdog on TX entry and every word request.
    assign load     = (next == GAP && state != GAP) || (state == START && next == TX) ||
                      (state == TX && next == TX && lanes_data_rqst);
    assign load_val = next == GAP ? CW'(GAP_CYCLES) : CW'(TIMEOUT_CYCLES - 1);

    dsi_sched_wdog #(.W(CW)) u_wdog (
        .clk_sys  (clk_sys),
        .rst_n    (rst_n),
        .load     (load),
        .load_val (load_val),
        .done     (done)
    );

    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n) begin
            src    <= SRC_VID;
            mode   <= MODE_HS;
            starve <= '0;
        end else if (state == ARB) begin
            if (grant_c) begin
                src    <= SRC_CMD;
                mode   <= cmd_lp ? MODE_LP : MODE_HS;
                starve <= '0;
            end else if (vid_valid) begin
                src    <= SRC_VID;
                mode   <= MODE_HS;
                starve <= cmd_valid && starve != 4'(STARVE_LIMIT) ? starve + 1'b1 : starve;
            end
        end

    always_ff @(posedge clk_sys or negedge rst_n)
        if (!rst_n) begin
            err_underrun <= 1'b0;
            err_timeout  <= 1'b0;
        end else begin
            err_underrun <= (err_underrun && enable) || underrun;
            err_timeout  <= (err_timeout && enable) || timeout;
        end

endmodule

// File: tb/tb_dsi_tx_packet_scheduler.sv
// tb_dsi_tx_packet_scheduler: directed self-checking bench for the DSI TX packet scheduler.
module tb_dsi_tx_packet_scheduler;

    logic        clk_sys = 1'b0;
    logic        rst_n;
    logic        enable, lanes_ready;
    logic        vid_valid, vid_last, vid_ack;
    logic [31:0] vid_data;
    logic [3:0]  vid_strb;
    logic        cmd_valid, cmd_lp, cmd_last, cmd_ack;
    logic [31:0] cmd_data;
    logic [3:0]  cmd_strb;
    logic [31:0] lanes_write_data;
    logic [4:0]  lanes_write_strb;
    logic        lanes_write_rqst, lanes_last_word, lanes_data_rqst;
    logic        busy, grant_cmd, err_underrun, err_timeout;

    int checks = 0;
    int errors = 0;
    int n;

    always #5 clk_sys = ~clk_sys;

    dsi_tx_packet_scheduler dut (
        .clk_sys          (clk_sys),
        .rst_n            (rst_n),
        .enable           (enable),
        .lanes_ready      (lanes_ready),
        .vid_valid        (vid_valid),
        .vid_data         (vid_data),
        .vid_strb         (vid_strb),
        .vid_last         (vid_last),
        .vid_ack          (vid_ack),
        .cmd_valid        (cmd_valid),
        .cmd_data         (cmd_data),
        .cmd_strb         (cmd_strb),
        .cmd_lp           (cmd_lp),
        .cmd_last         (cmd_last),
        .cmd_ack          (cmd_ack),
        .lanes_write_data (lanes_write_data),
        .lanes_write_strb (lanes_write_strb),
        .lanes_write_rqst (lanes_write_rqst),
        .lanes_last_word  (lanes_last_word),
        .lanes_data_rqst  (lanes_data_rqst),
        .busy             (busy),
        .grant_cmd        (grant_cmd),
        .err_underrun     (err_underrun),
        .err_timeout      (err_timeout)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step;
        @(posedge clk_sys);
        #1;
    endtask

    task automatic idle(input int c);
        repeat (c) step();
    endtask

    // Returns the number of cycles stepped until the start pulse is seen.
    task automatic wait_rqst(input string tag, output int cnt);
        cnt = 0;
        do begin
            step();
            #2;
            cnt++;
        end while (!lanes_write_rqst && cnt < 2000);
        chk(tag, lanes_write_rqst, 1'b1);
    endtask

    initial begin
        rst_n = 0; enable = 0; lanes_ready = 0; lanes_data_rqst = 0;
        vid_valid = 0; vid_data = '0; vid_strb = '0; vid_last = 0;
        cmd_valid = 0; cmd_data = '0; cmd_strb = '0; cmd_lp = 0; cmd_last = 0;
        idle(2);
        chk("rst_busy", busy, 0);
        chk("rst_rqst", lanes_write_rqst, 0);
        chk("rst_data", lanes_write_data, 0);
        chk("rst_strb", lanes_write_strb, 0);
        chk("rst_grant", grant_cmd, 0);
        chk("rst_errs", {err_underrun, err_timeout}, 0);
        rst_n = 1;

        // Three-word HS video packet, word request every second cycle
        step();
        enable = 1; lanes_ready = 1;
        vid_valid = 1; vid_data = 32'h11111111; vid_strb = 4'hF; vid_last = 0;
        wait_rqst("v_start", n);
        chk("v_lat", n, 2);
        chk("v_data0", lanes_write_data, 32'h11111111);
        chk("v_strb0", lanes_write_strb, 5'h0F);
        chk("v_grant", grant_cmd, 0);
        chk("v_busy", busy, 1);
        step(); #2;
        chk("v_rqst_pulse", lanes_write_rqst, 0);
        chk("v_noack", vid_ack, 0);
        step(); lanes_data_rqst = 1; #2;
        chk("v_ack0", vid_ack, 1);
        chk("v_last0", lanes_last_word, 0);
        step(); lanes_data_rqst = 0; vid_data = 32'h22222222;
        step(); lanes_data_rqst = 1; #2;
        chk("v_ack1", vid_ack, 1);
        chk("v_data1", lanes_write_data, 32'h22222222);
        step(); lanes_data_rqst = 0; vid_data = 32'h33333333; vid_last = 1;
        step(); lanes_data_rqst = 1; #2;
        chk("v_ack2", vid_ack, 1);
        chk("v_last2", lanes_last_word, 1);
        chk("v_data2", lanes_write_data, 32'h33333333);
        step(); lanes_data_rqst = 0; vid_data = 32'h44444444; #2;
        chk("gap_busy", busy, 0);
        chk("gap_data", lanes_write_data, 0);
        wait_rqst("v2_start", n);
        // 9 GAP cycles (8 down to 0), one IDLE, one ARB, then START
        chk("gap_len", n + 1, 12);
        chk("v2_data", lanes_write_data, 32'h44444444);
        step(); lanes_data_rqst = 1; #2;
        chk("v2_ack", vid_ack, 1);
        step(); lanes_data_rqst = 0; vid_valid = 0; vid_last = 0;
        idle(15);

        // LP command while video idle
        cmd_valid = 1; cmd_data = 32'hDEADBEEF; cmd_strb = 4'hF; cmd_lp = 1; cmd_last = 1;
        wait_rqst("c_start", n);
        chk("c_strb", lanes_write_strb, 5'h1F);
        chk("c_data", lanes_write_data, 32'hDEADBEEF);
        chk("c_grant", grant_cmd, 1);
        step(); lanes_data_rqst = 1; #2;
        chk("c_ack", cmd_ack, 1);
        chk("c_vidack", vid_ack, 0);
        step(); lanes_data_rqst = 0; cmd_valid = 0; #2;
        chk("c_single_ack", cmd_ack, 0);
        chk("c_done", busy, 0);
        chk("c_grant_hold", grant_cmd, 1);
        idle(15);

        // Starvation: four video grants, then the pending command, then video again
        vid_valid = 1; vid_last = 1; vid_data = 32'hA5A5A5A5; vid_strb = 4'h3;
        cmd_valid = 1; cmd_lp = 0; cmd_data = 32'hC0C0C0C0; cmd_last = 1;
        for (int k = 0; k < 6; k++) begin
            wait_rqst("s_start", n);
            chk("s_grant", grant_cmd, k == 4);
            chk("s_strb", lanes_write_strb, k == 4 ? 5'h0F : 5'h03);
            step(); lanes_data_rqst = 1; #2;
            chk("s_vack", vid_ack, k != 4);
            chk("s_cack", cmd_ack, k == 4);
            step(); lanes_data_rqst = 0;
        end
        vid_valid = 0; cmd_valid = 0; vid_strb = 4'hF;
        idle(15);

        // Underrun: video drops valid before the second word request
        vid_valid = 1; vid_last = 0; vid_data = 32'h55555555;
        wait_rqst("u_start", n);
        step(); lanes_data_rqst = 1; #2;
        chk("u_ack0", vid_ack, 1);
        step(); lanes_data_rqst = 0; vid_valid = 0;
        step(); lanes_data_rqst = 1; #2;
        chk("u_noack", vid_ack, 0);
        step(); #2;
        chk("u_err", err_underrun, 1);
        chk("u_gap", busy, 0);
        chk("u_noack_gap", vid_ack, 0);
        step(); lanes_data_rqst = 0;
        idle(15);

        // Stall: no word request after START
        vid_valid = 1; vid_last = 1; vid_data = 32'h66666666;
        wait_rqst("t_start", n);
        n = 0;
        do begin
            step(); #2; n++;
        end while (busy && n < 1100);
        vid_valid = 0;
        // START plus 1024 silent TX cycles, busy low on the next
        chk("t_len", n, 1025);
        chk("t_err", err_timeout, 1);
        chk("t_busy", busy, 0);
        chk("t_underrun_sticky", err_underrun, 1);
        step(); enable = 0;
        step(); #2;
        chk("clr_underrun", err_underrun, 0);
        chk("clr_timeout", err_timeout, 0);
        enable = 1;
        idle(15);

        // lanes_ready drop mid-TX aborts silently
        vid_valid = 1; vid_last = 0; vid_data = 32'h77777777;
        wait_rqst("r_start", n);
        step(); lanes_ready = 0; lanes_data_rqst = 1; #2;
        chk("r_noack", vid_ack, 0);
        step(); lanes_data_rqst = 0; lanes_ready = 1; vid_valid = 0; #2;
        chk("r_busy", busy, 0);
        chk("r_errs", {err_underrun, err_timeout}, 0);
        chk("r_data", lanes_write_data, 0);
        idle(15);

        // Asynchronous reset in TX
        vid_valid = 1; vid_data = 32'h88888888;
        wait_rqst("a_start", n);
        step(); #2;
        chk("a_busy_pre", busy, 1);
        lanes_data_rqst = 1; rst_n = 0; #1;
        chk("a_busy", busy, 0);
        chk("a_ack", vid_ack, 0);
        chk("a_data", lanes_write_data, 0);
        chk("a_strb", lanes_write_strb, 0);
        chk("a_last", lanes_last_word, 0);
        chk("a_rqst", lanes_write_rqst, 0);
        step(); rst_n = 1; lanes_data_rqst = 0;
        wait_rqst("a_restart", n);
        chk("a_from_idle", n, 2);
        chk("a_data2", lanes_write_data, 32'h88888888);
        step(); lanes_data_rqst = 1; vid_last = 1;
        step(); lanes_data_rqst = 0; vid_valid = 0;
        idle(5);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
